unsigned_mac_stream: RTL and testbench
======================================

// Module: unsigned_mac_stream
// PURPOSE
//  Streaming multiply-accumulate stage. Sits directly downstream of the team's N-bit combinational array multiplier.
//  Accepts unsigned operand pairs over valid/ready, registers the 2N-bit product and accumulates terms until in_last.
//  Then presents the packet sum, term count and overflow flag over valid/ready. Throughput: one term per cycle.
// PARAMETERS
//  N      4        operand width; product is 2N bits
//  ACC_W  2*N+4    accumulator/result width (must be >= 2*N)
//  LEN_W  4        term-counter width; count saturates at 2**LEN_W-1
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      stage can accept operand pair
//  in_x       in   N      unsigned multiplicand
//  in_y       in   N      unsigned multiplier
//  in_last    in   1      final term of packet
//  out_valid  out  1      packet result valid
//  out_ready  in   1      consumer accepts result
//  acc_out    out  ACC_W  packet sum of x*y
//  cnt_out    out  LEN_W  terms in packet (saturating)
//  ovf_out    out  1      sticky: accumulator exceeded ACC_W bits this packet
// BEHAVIOUR
//  Reset (async assert, sync deassert by system): state=ACC, p_valid=0, acc=0, cnt=0, ovf=0, first=1.
//    Outputs during reset: out_valid=0, acc_out=0, cnt_out=0, ovf_out=0, in_ready=1.
//  P stage: when in_valid&&in_ready, capture prod_q=in_x*in_y (2N bits, exact), last_q=in_last; set p_valid=1.
//    p_valid clears when A consumes and no new capture happens in that cycle.
//  A stage, state ACC, p_valid=1: consume prod_q.
//    If first=1: acc<=prod_q, cnt<=1, ovf<=0.
//    Else: acc<=acc+prod_q (ACC_W+1-bit sum), cnt<=cnt+1 saturating, ovf|=carry.
//    first<=last_q. If last_q: state<=DONE.
//  State DONE: out_valid=1; acc_out/cnt_out/ovf_out held stable until out_ready.
//    On out_ready: state<=ACC, first=1. A pending p_valid is not consumed in the handshake cycle; it is consumed next cycle.
//  in_ready = (state==ACC) || !p_valid. While DONE, one extra term may enter P and then stalls.
//  Latency: in_last accepted at cycle t -> out_valid high at t+2.
//  in_valid with in_last never set: accumulates indefinitely; cnt holds at max.
//  No input accepted with in_valid low; x/y ignored then.
//  rst_n low mid-packet: partial packet and P contents discarded; no spurious out_valid.
// CONFIGURATION
//  MAC_SATURATE_EN defined: on carry out, acc clamps to all-ones and stays clamped for the packet; ovf_out=1.
//  Undefined: acc wraps modulo 2**ACC_W; ovf_out=1. Result bits are the low ACC_W bits of the true sum.
// STRUCTURE
//  Shared package mac_pkg: state encoding (ACC, DONE), default ACC_W/LEN_W constants,
//    saturating-increment function.
//  Sub-module mac_prod_stage: P-stage product register with valid/ready (skid-free, 1 entry).
//  unsigned_mac_stream holds the A-stage accumulator FSM and output regs.
// TESTING (N=4, ACC_W=12, LEN_W=4)
//  1. Terms (15,15),(15,15),(1,1,last), out_ready=1 -> acc_out=451, cnt_out=3, ovf_out=0.
//     out_valid rises 2 cycles after last accept.
//  2. Single term (0,9,last) -> acc_out=0, cnt_out=1, ovf_out=0. Next packet (3,5,last) -> 15 (first-term clear verified).
//  3. out_ready=0 for 5 cycles after result; in_valid held high -> exactly one more term accepted.
//     in_ready stays 0 and acc_out stays stable. Release -> next packet sum correct.
//  4. 19 terms of (15,15): sum 4275.
//     Without MAC_SATURATE_EN -> acc_out=179, ovf_out=1, cnt_out=15.
//     With MAC_SATURATE_EN -> acc_out=4095, ovf_out=1, cnt_out=15.
//  5. rst_n low for 1 cycle after 2 terms of a packet -> out_valid=0, in_ready=1, all outputs 0.
//     Then (3,5,last) -> acc_out=15, cnt_out=1.
//  6. Random packets (1-8 terms), random in_valid/out_ready gaps, 1000 packets -> scoreboard matches model.
//     No accepted term is lost or duplicated.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the unsigned streaming MAC: state encoding, default
// widths and the saturating counter increment.
package mac_pkg;

    localparam int MAC_DEF_N     = 4;
    localparam int MAC_ACC_GUARD = 4;
    localparam int MAC_DEF_ACC_W = 2 * MAC_DEF_N + MAC_ACC_GUARD;
    localparam int MAC_DEF_LEN_W = 4;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } mac_state_t;

    // Increment that sticks at max_v instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mac_prod_stage.sv
// Product register stage: one-entry valid/ready holding register for the
// exact 2N-bit product and the packet-last marker.
module mac_prod_stage
    import mac_pkg::*;
#(
    parameter int N = MAC_DEF_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_x,
    input  logic [N-1:0]   in_y,
    input  logic           in_last,
    input  logic           p_ready,
    output logic           p_valid,
    output logic [2*N-1:0] prod_q,
    output logic           last_q
);

    logic capture;

    // A new pair can enter whenever the held product is leaving or the slot is empty.
    assign in_ready = p_ready || !p_valid;
    assign capture  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            prod_q  <= '0;
            last_q  <= 1'b0;
        end else if (capture) begin
            p_valid <= 1'b1;
            prod_q  <= {{N{1'b0}}, in_x} * {{N{1'b0}}, in_y};
            last_q  <= in_last;
        end else if (p_ready) begin
            p_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/unsigned_mac_stream.sv
// Streaming unsigned multiply-accumulate: sums x*y terms until in_last, then
// offers sum/count/overflow. Define MAC_SATURATE_EN to clamp instead of wrap.
module unsigned_mac_stream
    import mac_pkg::*;
#(
    parameter int N     = MAC_DEF_N,
    parameter int ACC_W = 2 * N + MAC_ACC_GUARD,
    parameter int LEN_W = MAC_DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_x,
    input  logic [N-1:0]     in_y,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [LEN_W-1:0] cnt_out,
    output logic             ovf_out
);

    localparam int          SUM_W   = ACC_W + 1;
    localparam logic [31:0] CNT_MAX = 32'((1 << LEN_W) - 1);

    mac_state_t       state, state_nx;
    logic [ACC_W-1:0] acc, acc_nx;
    logic [LEN_W-1:0] cnt, cnt_nx;
    logic             ovf, ovf_nx;
    logic             first, first_nx;
    logic [SUM_W-1:0] sum;
    logic             p_valid;
    logic [2*N-1:0]   prod_q;
    logic             last_q;

    mac_prod_stage #(.N(N)) u_prod (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_y     (in_y),
        .in_last  (in_last),
        .p_ready  (state == ST_ACC),
        .p_valid  (p_valid),
        .prod_q   (prod_q),
        .last_q   (last_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACC;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            first <= 1'b1;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            ovf   <= ovf_nx;
            first <= first_nx;
        end
    end

    // The extra bit of sum is the carry out of the accumulator.
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        ovf_nx   = ovf;
        first_nx = first;
        sum      = {1'b0, acc} + SUM_W'(prod_q);
        case (state)
            ST_ACC: begin
                if (p_valid) begin
                    if (first) begin
                        acc_nx = ACC_W'(prod_q);
                        cnt_nx = LEN_W'(1);
                        ovf_nx = 1'b0;
                    end else begin
`ifdef MAC_SATURATE_EN
                        acc_nx = (ovf || sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
`else
                        acc_nx = sum[ACC_W-1:0];
`endif
                        cnt_nx = LEN_W'(sat_inc(32'(cnt), CNT_MAX));
                        ovf_nx = ovf || sum[ACC_W];
                    end
                    first_nx = last_q;
                    if (last_q) begin
                        state_nx = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx = ST_ACC;
                    first_nx = 1'b1;
                end
            end
            default: state_nx = ST_ACC;
        endcase
    end

    assign out_valid = (state == ST_DONE);
    assign acc_out   = acc;
    assign cnt_out   = cnt;
    assign ovf_out   = ovf;

endmodule

// File: tb/tb_unsigned_mac_stream.sv
// Directed and random scoreboard bench for unsigned_mac_stream (N=4, ACC_W=12,
// LEN_W=4); honours MAC_SATURATE_EN in its reference model.
module tb_unsigned_mac_stream;

    localparam int N     = 4;
    localparam int ACC_W = 12;
    localparam int LEN_W = 4;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic [LEN_W-1:0] cnt;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_x;
    logic [N-1:0]     in_y;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic [LEN_W-1:0] cnt_out;
    logic             ovf_out;

    logic dir_ready;
    logic rnd_ready = 1'b1;
    logic rand_mode = 1'b0;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    int   pkts_in  = 0;
    int   pkts_out = 0;

    assign out_ready = rand_mode ? rnd_ready : dir_ready;

    always #5 clk = ~clk;

    unsigned_mac_stream #(.N(N), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .cnt_out   (cnt_out),
        .ovf_out   (ovf_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_result(input longint s, input int c);
        exp_t e;
        if (s > 4095) begin
`ifdef MAC_SATURATE_EN
            e.acc = '1;
`else
            e.acc = ACC_W'(s);
`endif
            e.ovf = 1'b1;
        end else begin
            e.acc = ACC_W'(s);
            e.ovf = 1'b0;
        end
        e.cnt = LEN_W'(c);
        return e;
    endfunction

    // Reference model and scoreboard, sampled mid-cycle ahead of the edge that commits it.
    longint           m_sum   = 0;
    int               m_cnt   = 0;
    bit               m_first = 1'b1;
    bit               hold    = 1'b0;
    logic [ACC_W-1:0] hold_acc;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_sum   = 0;
            m_cnt   = 0;
            m_first = 1'b1;
            hold    = 1'b0;
            sb.delete();
        end else begin
            if (in_valid && in_ready) begin
                if (m_first) begin
                    m_sum = 0;
                    m_cnt = 0;
                end
                m_sum   += longint'(in_x) * longint'(in_y);
                m_cnt   = (m_cnt < 15) ? m_cnt + 1 : 15;
                m_first = in_last;
                if (in_last) begin
                    sb.push_back(model_result(m_sum, m_cnt));
                    pkts_in++;
                end
            end
            if (hold) begin
                check("hold_acc_stable", 32'(acc_out), 32'(hold_acc));
                check("hold_valid", 32'(out_valid), 1);
            end
            hold     = out_valid && !out_ready;
            hold_acc = acc_out;
            if (out_valid && out_ready) begin
                check("sb_pending", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_acc", 32'(acc_out), 32'(e.acc));
                    check("sb_cnt", 32'(cnt_out), 32'(e.cnt));
                    check("sb_ovf", 32'(ovf_out), 32'(e.ovf));
                end
                pkts_out++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    // Drives one term and returns one ns after the edge that accepted it.
    task automatic applyStimulus(input logic [N-1:0] x, input logic [N-1:0] y, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waited < 1000) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_x     = N'($urandom);
        in_y     = N'($urandom);
        in_last  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input int e_acc, input int e_cnt, input int e_ovf);
        int waited = 0;
        @(negedge clk);
        while (!out_valid && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_acc"}, 32'(acc_out), 32'(e_acc));
        check({tag, "_cnt"}, 32'(cnt_out), 32'(e_cnt));
        check({tag, "_ovf"}, 32'(ovf_out), 32'(e_ovf));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int extra;
        int waited;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_last   = 1'b0;
        dir_ready = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_acc", 32'(acc_out), 0);
        check("rst_cnt", 32'(cnt_out), 0);
        check("rst_ovf", 32'(ovf_out), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(15, 15, 0);
        applyStimulus(15, 15, 0);
        applyStimulus(1, 1, 1);
        @(negedge clk);
        check("t1_lat_early", 32'(out_valid), 0);
        @(negedge clk);
        check("t1_lat_valid", 32'(out_valid), 1);
        check("t1_acc", 32'(acc_out), 451);
        check("t1_cnt", 32'(cnt_out), 3);
        check("t1_ovf", 32'(ovf_out), 0);
        @(posedge clk);
        #1;

        applyStimulus(0, 9, 1);
        checkOutput("t2a", 0, 1, 0);
        applyStimulus(3, 5, 1);
        checkOutput("t2b", 15, 1, 0);

        dir_ready = 1'b0;
        applyStimulus(2, 3, 1);
        in_valid = 1'b1;
        in_x     = 4;
        in_y     = 4;
        in_last  = 1'b1;
        extra    = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (in_valid && in_ready) extra++;
            if (i >= 1) begin
                check("t3_in_ready", 32'(in_ready), 0);
                check("t3_acc_hold", 32'(acc_out), 6);
            end
        end
        check("t3_extra_accepts", 32'(extra), 1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        dir_ready = 1'b1;
        checkOutput("t3a", 6, 1, 0);
        checkOutput("t3b", 16, 1, 0);

        for (int i = 0; i < 18; i++) applyStimulus(15, 15, 0);
        applyStimulus(15, 15, 1);
`ifdef MAC_SATURATE_EN
        checkOutput("t4", 4095, 15, 1);
`else
        checkOutput("t4", 179, 15, 1);
`endif

        applyStimulus(2, 2, 0);
        applyStimulus(2, 2, 0);
        rst_n = 1'b0;
        #1;
        check("t5_out_valid", 32'(out_valid), 0);
        check("t5_in_ready", 32'(in_ready), 1);
        check("t5_acc", 32'(acc_out), 0);
        check("t5_cnt", 32'(cnt_out), 0);
        check("t5_ovf", 32'(ovf_out), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(3, 5, 1);
        checkOutput("t5", 15, 1, 0);

        rand_mode = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            int terms;
            terms = $urandom_range(1, 8);
            for (int t = 0; t < terms; t++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                applyStimulus(N'($urandom), N'($urandom), t == terms - 1);
            end
        end
        rand_mode = 1'b0;
        waited    = 0;
        while ((sb.size() > 0 || out_valid) && waited < 200) begin
            waited++;
            @(posedge clk);
            #1;
        end
        check("drain_sb_empty", 32'(sb.size()), 0);
        check("drain_pkts", 32'(pkts_out), 32'(pkts_in));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
